nios_mtl_cpu_cpu_debug_mon_access: RTL and testbench

NIOS_MTL_CPU_CPU_DEBUG_MON_ACCESS -- requirements
Module: nios_mtl_cpu_cpu_debug_mon_access

---
 rtl/nios_mtl_debug_mon_pkg.sv | 31 +++
 rtl/nios_mtl_cpu_cpu_debug_mon_ram.sv | 30 +++
 rtl/nios_mtl_cpu_cpu_debug_mon_access.sv | 131 +++++++++++++
 tb/tb_nios_mtl_cpu_cpu_debug_mon_access.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_mtl_debug_mon_pkg.sv
// Shared definitions for the Nios debug monitor access block: FSM states,
// the out-of-range read pattern, the write-protect window size and the
// bit positions of the fields carried in the 38-bit JTAG data word.
package nios_mtl_debug_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_ADDR = 2'd1,
    ST_RD_DATA = 2'd2,
    ST_WR      = 2'd3
  } mon_state_e;

  // Returned in MonDReg when a read targets an unimplemented word
  localparam logic [31:0] MON_ERR_DATA = 32'hDEADDEAD;

  // Words below this address are read-only when write protection is built in
  localparam logic [31:0] WRPROT_LIMIT = 32'd64;

  // jdo field positions
  localparam int JDO_W           = 38;
  localparam int JDO_ADDR_LSB    = 17;
  localparam int JDO_RD_BIT      = 34;
  localparam int JDO_CLR_ERR_BIT = 35;
  localparam int JDO_DATA_MSB    = 34;
  localparam int JDO_DATA_LSB    = 3;

  function automatic logic is_wr_protected(input logic [31:0] word_addr);
    return (word_addr < WRPROT_LIMIT);
  endfunction

endpackage

// File: rtl/nios_mtl_cpu_cpu_debug_mon_ram.sv
// Single-port debug RAM, RAM_DEPTH x 32. Synchronous read with one clock of
// latency; a write also forwards the written word to the read port.
// Contents are deliberately not reset.
module nios_mtl_cpu_cpu_debug_mon_ram #(
  parameter int RAM_DEPTH = 256,
  parameter int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [RAM_DEPTH];

  // Registered access port, write-first on a write cycle
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata     <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/nios_mtl_cpu_cpu_debug_mon_access.sv
// Nios debug monitor access block. Decodes the three ocimem command pulses
// into RAM reads and writes through a four-state FSM, keeps the monitor
// address/data registers and a sticky error flag.
// RAM_DEPTH must be a power of two, at least 2 and at most 2**ADDR_W.
// Optional feature: define NIOS_MTL_DEBUG_MON_WRPROT_EN to make words
// 0..63 read-only (writes there are dropped and flag an error).
module nios_mtl_cpu_cpu_debug_mon_access
  import nios_mtl_debug_mon_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int RAM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] MonAReg
);

  localparam int          RAM_AW  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = RAM_DEPTH;

  mon_state_e        state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       data_nxt;
  logic              ready_nxt;
  logic              err_set, err_clr;
  logic              cmd_acc;
  logic              any_pulse;
  logic              in_range;
  logic              ram_en, ram_we;
  logic [31:0]       ram_rdata;
  logic              unused_jdo;

  assign any_pulse = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign in_range  = (32'(MonAReg) < DEPTH_U);
  assign unused_jdo = &{1'b0, jdo[2:0], jdo[37:36]};

  // Next-state, datapath next values and RAM strobes
  always_comb begin
    state_nxt = state;
    addr_nxt  = MonAReg;
    data_nxt  = MonDReg;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    cmd_acc   = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_acc = any_pulse;
        if (take_action_ocimem_b) begin
          data_nxt  = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
          state_nxt = ST_WR;
        end else if (take_action_ocimem_a) begin
          addr_nxt = jdo[JDO_ADDR_LSB +: ADDR_W];
          err_clr  = jdo[JDO_CLR_ERR_BIT];
          if (jdo[JDO_RD_BIT]) state_nxt = ST_RD_ADDR;
        end else if (take_no_action_ocimem_a) begin
          addr_nxt  = MonAReg + ADDR_W'(1);
          state_nxt = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        err_set   = any_pulse;
        ram_en    = in_range;
        state_nxt = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        err_set   = any_pulse | ~in_range;
        data_nxt  = in_range ? ram_rdata : MON_ERR_DATA;
        state_nxt = ST_IDLE;
      end
      ST_WR: begin
        err_set   = any_pulse | ~in_range;
`ifdef NIOS_MTL_DEBUG_MON_WRPROT_EN
        if (is_wr_protected(32'(MonAReg))) begin
          err_set = 1'b1;
        end else begin
          ram_en = in_range;
          ram_we = in_range;
        end
`else
        ram_en    = in_range;
        ram_we    = in_range;
`endif
        addr_nxt  = MonAReg + ADDR_W'(1);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    ready_nxt = (state_nxt == ST_IDLE) && !cmd_acc;
  end

  // State, address/data registers and sticky error; reset aborts any operation
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      state         <= state_nxt;
      MonAReg       <= addr_nxt;
      MonDReg       <= data_nxt;
      monitor_ready <= ready_nxt;
      if (err_set)      monitor_error <= 1'b1;
      else if (err_clr) monitor_error <= 1'b0;
    end
  end

  // RAM strobes are gated by reset so an interrupted write never commits
  nios_mtl_cpu_cpu_debug_mon_ram #(
    .RAM_DEPTH (RAM_DEPTH),
    .RAM_AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en & reset_n),
    .we    (ram_we & reset_n),
    .addr  (MonAReg[RAM_AW-1:0]),
    .wdata (MonDReg),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_nios_mtl_cpu_cpu_debug_mon_access.sv
// Bench for the debug monitor access block: directed scenarios followed by
// randomized command sequences, compared against a transaction-level model
// (array of words, current address, data and error flag).
module tb_nios_mtl_cpu_cpu_debug_mon_access;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic [9:0]  MonAReg;

  always #5 clk = ~clk;

  nios_mtl_cpu_cpu_debug_mon_access #(
    .ADDR_W    (10),
    .RAM_DEPTH (DEPTH)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .MonAReg                 (MonAReg)
  );

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model state
  logic [31:0] mem_m   [DEPTH];
  bit          valid_m [DEPTH];
  logic [9:0]  addr_m;
  logic [31:0] data_m;
  bit          data_known;
  logic        err_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] rnd_jdo();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[37:0];
  endfunction

  function automatic logic [37:0] mk_a(input logic [9:0] a, input bit rd, input bit clr);
    logic [37:0] j;
    j = rnd_jdo();
    j[26:17] = a;
    j[34]    = rd;
    j[35]    = clr;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = rnd_jdo();
    j[34:3] = d;
    return j;
  endfunction

  function automatic logic [9:0] pick_addr();
    int s;
    s = $urandom_range(0, 9);
    if (s < 6)       return 10'($urandom_range(0, DEPTH - 1));
    else if (s == 6) return 10'($urandom_range(DEPTH, 1022));
    else if (s == 7) return 10'd1023;
    else             return 10'($urandom_range(DEPTH - 6, DEPTH - 1));
  endfunction

  // Model of a read of the current address once it completes
  task automatic model_read();
    if (addr_m < 10'(DEPTH)) begin
      data_known = valid_m[addr_m];
      data_m     = mem_m[addr_m];
    end else begin
      data_known = 1'b1;
      data_m     = 32'hDEADDEAD;
      err_m      = 1'b1;
    end
  endtask

  // Model of the write of data_m at the current address
  task automatic model_write();
    if (addr_m >= 10'(DEPTH)) begin
      err_m = 1'b1;
`ifdef NIOS_MTL_DEBUG_MON_WRPROT_EN
    end else if (addr_m < 10'd64) begin
      err_m = 1'b1;
`endif
    end else begin
      mem_m[addr_m]   = data_m;
      valid_m[addr_m] = 1'b1;
    end
    addr_m = addr_m + 10'd1;
  endtask

  // One command: pulse(s) for one cycle, optional stray pulse(s) while busy,
  // then wait the fixed latency and compare all outputs with the model.
  task automatic op(input bit pa, input bit pna, input bit pb,
                    input logic [37:0] j, input logic [2:0] busy);
    int kind;  // 1 load only, 2 write, 3 read
    if (pb) begin
      kind       = 2;
      data_m     = j[34:3];
      data_known = 1'b1;
    end else if (pa) begin
      addr_m = j[26:17];
      if (j[35]) err_m = 1'b0;
      kind = j[34] ? 3 : 1;
    end else begin
      addr_m = addr_m + 10'd1;
      kind   = 3;
    end
    jdo                     = j;
    take_action_ocimem_a    = pa;
    take_no_action_ocimem_a = pna;
    take_action_ocimem_b    = pb;
    cyc();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    check("ready_drop", 32'(monitor_ready), 32'd0);
    if (busy != 3'd0 && kind != 1) begin
      jdo                     = rnd_jdo();
      take_action_ocimem_a    = busy[0];
      take_no_action_ocimem_a = busy[1];
      take_action_ocimem_b    = busy[2];
      err_m                   = 1'b1;
    end
    cyc();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    if (kind == 2) model_write();
    if (kind == 3) begin
      cyc();
      model_read();
    end
    check("ready_done", 32'(monitor_ready), 32'd1);
    check("mon_a_reg", 32'(MonAReg), 32'(addr_m));
    check("mon_error", 32'(monitor_error), 32'(err_m));
    if (data_known) check("mon_d_reg", MonDReg, data_m);
  endtask

  initial begin
    int          sel;
    logic [2:0]  busy;

    reset_n                 = 1'b0;
    jdo                     = '0;
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    for (int i = 0; i < DEPTH; i++) valid_m[i] = 1'b0;
    addr_m = '0; data_m = '0; data_known = 1'b1; err_m = 1'b0;

    cyc();
    cyc();
    check("rst_ready", 32'(monitor_ready), 32'd1);
    check("rst_addr",  32'(MonAReg), 32'd0);
    check("rst_data",  MonDReg, 32'd0);
    check("rst_error", 32'(monitor_error), 32'd0);
    reset_n = 1'b1;
    cyc();

    // Fill the RAM so every later read has a known expected value
    op(1, 0, 0, mk_a(10'd0, 0, 1), 3'd0);
    for (int i = 0; i < DEPTH; i++) op(0, 0, 1, mk_b($urandom), 3'd0);
    op(1, 0, 0, mk_a(10'd0, 0, 1), 3'd0);

    // Write 12345678 at address 5
    op(1, 0, 0, mk_a(10'd5, 0, 1), 3'd0);
    op(0, 0, 1, mk_b(32'h12345678), 3'd0);
    check("wr5_addr", 32'(MonAReg), 32'd6);

    // Read it back through an address load with read
    op(1, 0, 0, mk_a(10'd5, 1, 0), 3'd0);
`ifndef NIOS_MTL_DEBUG_MON_WRPROT_EN
    check("rd5_data", MonDReg, 32'h12345678);
    check("rd5_error", 32'(monitor_error), 32'd0);
`endif

    // Increment across the top of the address space, then unmapped read
    op(1, 0, 0, mk_a(10'd1023, 0, 1), 3'd0);
    op(0, 1, 0, rnd_jdo(), 3'd0);
    check("wrap_addr", 32'(MonAReg), 32'd0);
    check("wrap_error", 32'(monitor_error), 32'd0);
    op(1, 0, 0, mk_a(10'd300, 1, 0), 3'd0);
    check("oor_data", MonDReg, 32'hDEADDEAD);
    check("oor_error", 32'(monitor_error), 32'd1);

    // Simultaneous write and load: only the write runs
    op(1, 0, 0, mk_a(10'd100, 0, 1), 3'd0);
    op(1, 0, 1, mk_a(10'd7, 1, 1), 3'd0);
    // Stray pulse while a read is in progress
    op(1, 0, 0, mk_a(10'd20, 1, 1), 3'b010);
    check("busy_error", 32'(monitor_error), 32'd1);

    // Reset in the middle of a write: write must not land
    op(1, 0, 0, mk_a(10'd200, 0, 1), 3'd0);
    jdo                  = mk_b(32'hCAFEF00D);
    take_action_ocimem_b = 1'b1;
    cyc();
    take_action_ocimem_b = 1'b0;
    reset_n = 1'b0;
    cyc();
    addr_m = '0; data_m = '0; data_known = 1'b1; err_m = 1'b0;
    check("rstwr_ready", 32'(monitor_ready), 32'd1);
    check("rstwr_addr",  32'(MonAReg), 32'd0);
    check("rstwr_data",  MonDReg, 32'd0);
    check("rstwr_error", 32'(monitor_error), 32'd0);
    reset_n = 1'b1;
    cyc();
    op(1, 0, 0, mk_a(10'd200, 1, 0), 3'd0);

`ifdef NIOS_MTL_DEBUG_MON_WRPROT_EN
    // Protected word: write is discarded but the address still advances
    op(1, 0, 0, mk_a(10'd10, 0, 1), 3'd0);
    op(0, 0, 1, mk_b(32'hFFFFFFFF), 3'd0);
    check("prot_error", 32'(monitor_error), 32'd1);
    check("prot_addr", 32'(MonAReg), 32'd11);
    op(1, 0, 0, mk_a(10'd10, 1, 1), 3'd0);
    check("prot_data_kept", 32'(MonDReg === 32'hFFFFFFFF), 32'd0);
`endif

    // Randomized command mix
    for (int i = 0; i < 300; i++) begin
      sel  = $urandom_range(0, 9);
      busy = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      if (sel < 3)
        op(0, 0, 1, mk_b($urandom), busy);
      else if (sel < 6)
        op(1, 0, 0, mk_a(pick_addr(), $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0), busy);
      else if (sel < 8)
        op(0, 1, 0, rnd_jdo(), busy);
      else
        op(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
           mk_a(pick_addr(), 1, 0), busy);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
